// File: rtl/bp_pkg.sv
// Types shared by the branch-predictor redirect controller: next-PC select
// encodings, controller FSM states and the in-flight prediction record.
package bp_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JAL    = 2'b10,
    SEL_JALR   = 2'b11
  } next_pc_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    REDIRECT = 2'b01,
    DRAIN    = 2'b10
  } bp_state_e;

  // Queue records are sized for the widest supported PC (ADDRESS_BITS <= 32);
  // narrower PCs are zero-extended, so unused upper bits are constant zero.
  localparam int unsigned PC_MAX_BITS = 32;
  typedef logic [PC_MAX_BITS-1:0] pc_max_t;

  typedef struct packed {
    pc_max_t pc;
    logic    predict_taken;
    pc_max_t predicted_address;
  } pred_entry_t;

endpackage

// File: rtl/bp_redirect_ctrl_if.sv
// Fetch-side and EX/MEM-side signals of the redirect controller. The pipeline
// drives through the master modport; the controller attaches as slave.
interface bp_redirect_ctrl_if #(
  parameter int unsigned ADDRESS_BITS = 20
);

  logic                    if_fire;
  logic [ADDRESS_BITS-1:0] if_inst_PC;
  logic                    predict_taken;
  logic [ADDRESS_BITS-1:0] predicted_address;

  logic                    exmem_valid;
  logic [ADDRESS_BITS-1:0] exmem_inst_PC;
  logic [1:0]              exmem_next_PC_sel;
  logic                    exmem_ALU_branch;
  logic [ADDRESS_BITS-1:0] exmem_branch_target;
  logic [ADDRESS_BITS-1:0] exmem_JAL_target;
  logic [ADDRESS_BITS-1:0] exmem_JALR_target;

  logic                    fetch_hold;
  logic                    redirect_valid;
  logic [ADDRESS_BITS-1:0] redirect_PC;
  logic                    flush_ifid;
  logic                    flush_idex;

  modport master (
    output if_fire, if_inst_PC, predict_taken, predicted_address,
    output exmem_valid, exmem_inst_PC, exmem_next_PC_sel, exmem_ALU_branch,
    output exmem_branch_target, exmem_JAL_target, exmem_JALR_target,
    input  fetch_hold, redirect_valid, redirect_PC, flush_ifid, flush_idex
  );

  modport slave (
    input  if_fire, if_inst_PC, predict_taken, predicted_address,
    input  exmem_valid, exmem_inst_PC, exmem_next_PC_sel, exmem_ALU_branch,
    input  exmem_branch_target, exmem_JAL_target, exmem_JALR_target,
    output fetch_hold, redirect_valid, redirect_PC, flush_ifid, flush_idex
  );

endinterface

// File: rtl/bp_pred_queue.sv
// Circular FIFO of in-flight predictions with a synchronous clear. A push is
// accepted when not full, or when full and a pop frees a slot in the same cycle.
module bp_pred_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  pred_entry_t push_data_i,
  output pred_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  pred_entry_t      mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; count/pointers alone define which entries are valid.
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/bp_redirect_ctrl.sv
// Checks each retiring prediction against the resolved next PC; on a mismatch
// issues a one-cycle redirect with flushes, drains wrong-path work, keeps stats.
module bp_redirect_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS   = 20,
  parameter int unsigned INFLIGHT_DEPTH = 4,
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  bp_redirect_ctrl_if.slave    bus,
  output logic                 sync_error,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  bp_state_e               state_q, state_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic [ADDRESS_BITS-1:0] redirect_pc_q, redirect_pc_d;
  logic                    sync_error_q, sync_error_d;
  logic [CNT_WIDTH-1:0]    branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]    mispred_cnt_q, mispred_cnt_d;

  pred_entry_t             push_entry, head;
  logic                    q_full, q_empty, q_push, q_pop, q_clear;
  logic [ADDRESS_BITS-1:0] seq_pc, actual_pc;
  logic                    check, pc_mismatch, addr_mismatch, mispredict, sync_hit;
  logic                    unused_taken;

  assign push_entry.pc                = pc_max_t'(bus.if_inst_PC);
  assign push_entry.predict_taken     = bus.predict_taken;
  assign push_entry.predicted_address = pc_max_t'(bus.predicted_address);

  // Fetch continues through DRAIN so the redirected path can enter the queue.
  assign q_push  = bus.if_fire && (state_q != REDIRECT);
  assign q_clear = (state_q == REDIRECT);

  bp_pred_queue #(
    .DEPTH (INFLIGHT_DEPTH)
  ) u_queue (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (q_clear),
    .push_i      (q_push),
    .pop_i       (q_pop),
    .push_data_i (push_entry),
    .head_o      (head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  // The address comparison already captures direction; the taken bit is kept for debug.
  assign unused_taken = head.predict_taken;

  always_comb begin
    seq_pc    = bus.exmem_inst_PC + ADDRESS_BITS'(4);
    actual_pc = seq_pc;
    case (next_pc_sel_e'(bus.exmem_next_PC_sel))
      SEL_SEQ:    actual_pc = seq_pc;
      SEL_BRANCH: actual_pc = bus.exmem_ALU_branch ? bus.exmem_branch_target : seq_pc;
      SEL_JAL:    actual_pc = bus.exmem_JAL_target;
      SEL_JALR:   actual_pc = bus.exmem_JALR_target;
      default:    actual_pc = seq_pc;
    endcase
  end

  // Wrong-path instructions reaching EX/MEM outside RUN are neither popped nor compared.
  assign check         = bus.exmem_valid && (state_q == RUN);
  assign q_pop         = check && !q_empty;
  assign pc_mismatch   = head.pc != pc_max_t'(bus.exmem_inst_PC);
  assign addr_mismatch = head.predicted_address != pc_max_t'(actual_pc);
  assign mispredict    = check && (q_empty || pc_mismatch || addr_mismatch);
  assign sync_hit      = check && (q_empty || pc_mismatch);

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d       = REDIRECT;
          redirect_pc_d = actual_pc;
        end
      end
      REDIRECT: begin
        state_d = DRAIN;
        drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        if (drain_q == '0) state_d = RUN;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    sync_error_d  = sync_error_q | sync_hit;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (q_pop && (bus.exmem_next_PC_sel != SEL_SEQ) && !(&branch_cnt_q))
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
    if (mispredict && !(&mispred_cnt_q))
      mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      drain_q       <= '0;
      redirect_pc_q <= '0;
      sync_error_q  <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      redirect_pc_q <= redirect_pc_d;
      sync_error_q  <= sync_error_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.fetch_hold     = q_full || (state_q == REDIRECT);
  assign bus.redirect_valid = (state_q == REDIRECT);
  assign bus.redirect_PC    = redirect_pc_q;
  assign bus.flush_ifid     = (state_q == REDIRECT);
  assign bus.flush_idex     = (state_q == REDIRECT);
  assign sync_error         = sync_error_q;
  assign branch_count       = branch_cnt_q;
  assign mispredict_count   = mispred_cnt_q;

endmodule
